// File: rtl/osd_char_renderer.sv
// osd_char_renderer
// Pulls character codes from the OSD character buffer one at a time, looks
// each code up in an external font ROM and serializes the font row into
// foreground/background pixels on a valid/ready pixel stream.
module osd_char_renderer #(
    parameter int FONT_WIDTH        = 5,
    parameter int FONT_HEIGHT       = 8,   // must not exceed 2**FONT_ROW_BITS
    parameter int FONT_ROW_BITS     = 3,
    parameter int CHAR_IMAGE_WIDTH  = 80,
    parameter int CHAR_IMAGE_HEIGHT = 34,
    parameter int PIXEL_WIDTH       = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start_frame_stb,
    output logic                       o_read_frame_stb,
    output logic                       o_char_req_en,
    input  logic                       i_char_rdy,
    input  logic [7:0]                 i_char,
    output logic [8+FONT_ROW_BITS-1:0] o_font_addr,
    input  logic [FONT_WIDTH-1:0]      i_font_row,
    input  logic [PIXEL_WIDTH-1:0]     i_fg_color,
    input  logic [PIXEL_WIDTH-1:0]     i_bg_color,
    output logic [PIXEL_WIDTH-1:0]     o_pixel_data,
    output logic                       o_pixel_valid,
    input  logic                       i_pixel_ready,
    output logic                       o_pixel_sof,
    output logic                       o_pixel_eol,
    output logic                       o_frame_done,
    output logic                       o_busy
);

    // Counter widths; a dimension of 1 still gets a 1-bit counter that stays 0.
    localparam int PIX_W  = (FONT_WIDTH > 1)        ? $clog2(FONT_WIDTH)        : 1;
    localparam int COL_W  = (CHAR_IMAGE_WIDTH > 1)  ? $clog2(CHAR_IMAGE_WIDTH)  : 1;
    localparam int TROW_W = (CHAR_IMAGE_HEIGHT > 1) ? $clog2(CHAR_IMAGE_HEIGHT) : 1;

    localparam logic [PIX_W-1:0]         PIX_MAX  = PIX_W'(FONT_WIDTH - 1);
    localparam logic [COL_W-1:0]         COL_MAX  = COL_W'(CHAR_IMAGE_WIDTH - 1);
    localparam logic [FONT_ROW_BITS-1:0] FROW_MAX = FONT_ROW_BITS'(FONT_HEIGHT - 1);
    localparam logic [TROW_W-1:0]        TROW_MAX = TROW_W'(CHAR_IMAGE_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_REQ,
        S_ADDR,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic [7:0]               char_q;
    logic [FONT_WIDTH-1:0]    shift_q;
    logic [PIXEL_WIDTH-1:0]   fg_q;
    logic [PIXEL_WIDTH-1:0]   bg_q;
    logic [PIX_W-1:0]         pix;
    logic [COL_W-1:0]         col;
    logic [FONT_ROW_BITS-1:0] frow;
    logic [TROW_W-1:0]        trow;

    logic last_pix;
    logic last_col;
    logic last_frow;
    logic last_trow;
    logic frame_end;
    logic pixel_fire;

    assign last_pix   = (pix  == PIX_MAX);
    assign last_col   = (col  == COL_MAX);
    assign last_frow  = (frow == FROW_MAX);
    assign last_trow  = (trow == TROW_MAX);
    assign frame_end  = last_pix && last_col && last_frow && last_trow;
    assign pixel_fire = (state == S_SHIFT) && i_pixel_ready;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: walk the per-character request/load/shift sequence.
    // NOTE: the default assignment first keeps this combinational block
    // from inferring a latch on paths that do not change state.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (i_start_frame_stb) state_next = S_START;
            S_START: state_next = S_REQ;
            S_REQ:   if (i_char_rdy) state_next = S_ADDR;
            S_ADDR:  state_next = S_LOAD;
            S_LOAD:  state_next = S_SHIFT;
            S_SHIFT: if (pixel_fire && last_pix) state_next = frame_end ? S_DONE : S_REQ;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: every output is a function of state and registered data.
    always_comb begin
        o_read_frame_stb = 1'b0;
        o_char_req_en    = 1'b0;
        o_pixel_valid    = 1'b0;
        o_pixel_data     = '0;
        o_pixel_sof      = 1'b0;
        o_pixel_eol      = 1'b0;
        o_frame_done     = 1'b0;
        o_busy           = (state != S_IDLE);
        // Address is held from registers, so it is 0 out of reset and
        // stays stable through ADDR for the ROM to sample.
        o_font_addr      = {char_q, frow};
        case (state)
            S_START: o_read_frame_stb = 1'b1;
            S_REQ:   o_char_req_en    = 1'b1;
            S_SHIFT: begin
                o_pixel_valid = 1'b1;
                o_pixel_data  = shift_q[FONT_WIDTH-1] ? fg_q : bg_q;
                o_pixel_sof   = (pix == '0) && (col == '0) && (frow == '0) && (trow == '0);
                o_pixel_eol   = last_pix && last_col;
            end
            S_DONE:  o_frame_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: colour capture, character latch, font shift register and
    // the pix -> col -> frow -> trow position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_q  <= '0;
            shift_q <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            pix     <= '0;
            col     <= '0;
            frow    <= '0;
            trow    <= '0;
        end else begin
            case (state)
                S_START: begin
                    fg_q <= i_fg_color;
                    bg_q <= i_bg_color;
                    pix  <= '0;
                    col  <= '0;
                    frow <= '0;
                    trow <= '0;
                end
                // Characters arriving in any other state are discarded.
                S_REQ:   if (i_char_rdy) char_q <= i_char;
                S_LOAD:  shift_q <= i_font_row;
                S_SHIFT: begin
                    if (pixel_fire) begin
                        shift_q <= shift_q << 1;
                        if (last_pix) begin
                            pix <= '0;
                            if (last_col) begin
                                col <= '0;
                                if (last_frow) begin
                                    frow <= '0;
                                    trow <= last_trow ? '0 : trow + TROW_W'(1);
                                end else begin
                                    frow <= frow + FONT_ROW_BITS'(1);
                                end
                            end else begin
                                col <= col + COL_W'(1);
                            end
                        end else begin
                            pix <= pix + PIX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_char_renderer.sv
// Self-checking bench for osd_char_renderer: a 1x1x1 instance driven from a
// vector table, and a 4x2 text, 8-row font instance rendered against a
// character-buffer model and pixel scoreboard.
module tb_osd_char_renderer;

    localparam int FW    = 5;
    localparam int PW    = 24;
    localparam int RB    = 3;
    localparam int B_CIW = 4;
    localparam int B_CIH = 2;
    localparam int B_FH  = 8;
    localparam int B_CHARS = B_CIW * B_FH * B_CIH;
    localparam int B_PIX   = B_CHARS * FW;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          sof;
        logic          eol;
    } pix_t;

    typedef struct packed {
        logic [7:0]    ch;
        logic [FW-1:0] rom;
        logic [PW-1:0] fg;
        logic [PW-1:0] bg;
        logic [10:0]   addr;
        logic [PW-1:0] p0;
        logic [PW-1:0] p1;
        logic [PW-1:0] p2;
        logic [PW-1:0] p3;
        logic [PW-1:0] p4;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Small instance signals
    logic          s_start, s_rfs, s_req, s_rdy, s_valid, s_ready, s_sof, s_eol, s_done, s_busy;
    logic [7:0]    s_char;
    logic [10:0]   s_addr;
    logic [FW-1:0] s_font_row, s_rom_pattern;
    logic [PW-1:0] s_fg, s_bg, s_data;

    // Large instance signals
    logic          b_start, b_rfs, b_req, b_rdy, b_valid, b_ready, b_sof, b_eol, b_done, b_busy;
    logic [7:0]    b_char;
    logic [10:0]   b_addr;
    logic [FW-1:0] b_font_row;
    logic [PW-1:0] b_fg, b_bg, b_data;

    pix_t sq_s[$];
    pix_t sq_b[$];
    vec_t vecs[4];

    int s_acc, s_last_acc;
    int b_acc, b_eols, b_sofs, b_rfs_cnt, b_done_cnt;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    osd_char_renderer #(
        .FONT_WIDTH(FW), .FONT_HEIGHT(1), .FONT_ROW_BITS(RB),
        .CHAR_IMAGE_WIDTH(1), .CHAR_IMAGE_HEIGHT(1), .PIXEL_WIDTH(PW)
    ) u_small (
        .clk(clk), .rst(rst),
        .i_start_frame_stb(s_start), .o_read_frame_stb(s_rfs),
        .o_char_req_en(s_req), .i_char_rdy(s_rdy), .i_char(s_char),
        .o_font_addr(s_addr), .i_font_row(s_font_row),
        .i_fg_color(s_fg), .i_bg_color(s_bg),
        .o_pixel_data(s_data), .o_pixel_valid(s_valid), .i_pixel_ready(s_ready),
        .o_pixel_sof(s_sof), .o_pixel_eol(s_eol),
        .o_frame_done(s_done), .o_busy(s_busy)
    );

    osd_char_renderer #(
        .FONT_WIDTH(FW), .FONT_HEIGHT(B_FH), .FONT_ROW_BITS(RB),
        .CHAR_IMAGE_WIDTH(B_CIW), .CHAR_IMAGE_HEIGHT(B_CIH), .PIXEL_WIDTH(PW)
    ) u_big (
        .clk(clk), .rst(rst),
        .i_start_frame_stb(b_start), .o_read_frame_stb(b_rfs),
        .o_char_req_en(b_req), .i_char_rdy(b_rdy), .i_char(b_char),
        .o_font_addr(b_addr), .i_font_row(b_font_row),
        .i_fg_color(b_fg), .i_bg_color(b_bg),
        .o_pixel_data(b_data), .o_pixel_valid(b_valid), .i_pixel_ready(b_ready),
        .o_pixel_sof(b_sof), .o_pixel_eol(b_eol),
        .o_frame_done(b_done), .o_busy(b_busy)
    );

    function automatic logic [FW-1:0] font_fn(input logic [10:0] a);
        return a[4:0] ^ a[9:5] ^ {a[10], a[2:0], 1'b1};
    endfunction

    function automatic logic [7:0] char_fn(input int k);
        return 8'(k * 37 + 11);
    endfunction

    function automatic logic [PW-1:0] vec_px(input vec_t t, input int p);
        case (p)
            0: return t.p0;
            1: return t.p1;
            2: return t.p2;
            3: return t.p3;
            default: return t.p4;
        endcase
    endfunction

    // Font ROMs with one cycle of read latency.
    always @(posedge clk) s_font_row <= s_rom_pattern;
    always @(posedge clk) b_font_row <= font_fn(b_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Small-instance monitor: handshake hold rule and scoreboard pop.
    pix_t s_prev;
    logic s_prev_stall = 1'b0;
    always @(negedge clk) begin
        pix_t got;
        pix_t e;
        got = '{data: s_data, sof: s_sof, eol: s_eol};
        if (rst) begin
            s_prev_stall = 1'b0;
        end else begin
            if (s_prev_stall) begin
                check("s_hold_valid", 32'(s_valid), 32'd1);
                check("s_hold_pixel", 32'(got), 32'(s_prev));
            end
            if (s_valid && s_ready) begin
                if (sq_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL s_extra_pixel: actual %0h required none", got);
                end else begin
                    e = sq_s.pop_front();
                    check("s_pixel", 32'(got), 32'(e));
                end
                s_acc++;
                s_last_acc = cyc;
            end
            s_prev_stall = s_valid && !s_ready;
            s_prev       = got;
        end
    end

    // Large-instance monitor: handshake hold rule, scoreboard pop, frame counts.
    pix_t b_prev;
    logic b_prev_stall = 1'b0;
    always @(negedge clk) begin
        pix_t got;
        pix_t e;
        got = '{data: b_data, sof: b_sof, eol: b_eol};
        if (rst) begin
            b_prev_stall = 1'b0;
        end else begin
            if (b_prev_stall) begin
                check("b_hold_valid", 32'(b_valid), 32'd1);
                check("b_hold_pixel", 32'(got), 32'(b_prev));
            end
            if (b_valid && b_ready) begin
                if (sq_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_extra_pixel: actual %0h required none", got);
                end else begin
                    e = sq_b.pop_front();
                    check("b_pixel", 32'(got), 32'(e));
                end
                b_acc++;
                if (b_eol) b_eols++;
                if (b_sof) b_sofs++;
            end
            if (b_rfs)  b_rfs_cnt++;
            if (b_done) b_done_cnt++;
            b_prev_stall = b_valid && !b_ready;
            b_prev       = got;
        end
    end

    task automatic check_small_idle(input string name);
        check(name, 32'({s_rfs, s_req, s_addr, s_valid, s_sof, s_eol, s_done, s_busy}), 32'd0);
        check("s_idle_data", 32'(s_data), 32'd0);
    endtask

    task automatic check_big_idle(input string name);
        check(name, 32'({b_rfs, b_req, b_addr, b_valid, b_sof, b_eol, b_done, b_busy}), 32'd0);
        check("b_idle_data", 32'(b_data), 32'd0);
    endtask

    // One single-character frame on the small instance from table entry v;
    // with bp set, the 3rd pixel is stalled for 3 cycles and a stray char is offered.
    task automatic run_small(input int v, input bit bp);
        vec_t t;
        bit   got_done;
        t = vecs[v];
        s_acc = 0;
        s_fg = t.fg;
        s_bg = t.bg;
        s_rom_pattern = t.rom;
        s_ready = 1'b1;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        check("s_read_stb", 32'(s_rfs), 32'd1);
        check("s_busy_start", 32'(s_busy), 32'd1);
        check("s_no_req_in_start", 32'(s_req), 32'd0);
        step();
        check("s_req_en", 32'(s_req), 32'd1);
        check("s_read_stb_pulse", 32'(s_rfs), 32'd0);
        s_rdy  = 1'b1;
        s_char = t.ch;
        for (int p = 0; p < FW; p++) begin
            sq_s.push_back('{data: vec_px(t, p), sof: (p == 0), eol: (p == FW - 1)});
        end
        step();
        s_rdy = 1'b0;
        check("s_font_addr", 32'(s_addr), 32'(t.addr));
        check("s_req_drop", 32'(s_req), 32'd0);
        check("s_no_valid_addr", 32'(s_valid), 32'd0);
        step();
        check("s_no_valid_load", 32'(s_valid), 32'd0);
        step();
        check("s_first_valid", 32'(s_valid), 32'd1);
        if (bp) begin
            step();
            step();
            s_ready = 1'b0;
            s_rdy   = 1'b1;
            s_char  = 8'hEE;
            for (int k = 0; k < 3; k++) begin
                step();
                s_rdy = 1'b0;
                check("s_stall_valid", 32'(s_valid), 32'd1);
                check("s_stall_data", 32'(s_data), 32'(t.p2));
            end
            s_ready = 1'b1;
            check("s_addr_after_stray", 32'(s_addr), 32'(t.addr));
        end
        got_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (s_done) begin
                got_done = 1'b1;
                break;
            end
            step();
        end
        check("s_done_seen", 32'(got_done), 32'd1);
        check("s_done_timing", 32'(cyc - s_last_acc), 32'd1);
        check("s_pixel_count", 32'(s_acc), 32'(FW));
        check("s_sb_empty", 32'(sq_s.size()), 32'd0);
        step();
        check("s_idle_after_done", 32'({s_busy, s_done}), 32'd0);
    endtask

    // One frame on the large instance against the buffer model. abort_at>0
    // resets mid-frame once that many chars are sent; busy_at/colour_at>0
    // inject a start strobe / colour change once that many chars are sent.
    task automatic run_big(input logic [PW-1:0] fg, input logic [PW-1:0] bg,
                           input int abort_at, input int busy_at, input int colour_at);
        int          sent;
        int          delay;
        bit          waiting;
        bit          addr_pending;
        bit          busy_done;
        bit          got_done;
        logic [10:0] exp_addr;
        logic [7:0]  ch;
        logic [FW-1:0] row;
        int          col;
        int          fr;
        sent = 0; delay = 0; waiting = 0; addr_pending = 0; busy_done = 0; got_done = 0;
        exp_addr = '0;
        b_acc = 0; b_eols = 0; b_sofs = 0; b_rfs_cnt = 0; b_done_cnt = 0;
        sq_b.delete();
        b_fg = fg;
        b_bg = bg;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (b_done) begin
                got_done = 1'b1;
                break;
            end
            b_start = 1'b0;
            b_ready = ($urandom_range(3) != 0);
            if (addr_pending) begin
                check("b_font_addr", 32'(b_addr), 32'(exp_addr));
                addr_pending = 1'b0;
            end
            if (abort_at > 0 && sent == abort_at && b_valid) begin
                b_rdy = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_big_idle("b_idle_after_abort");
                sq_b.delete();
                return;
            end
            if (busy_at > 0 && sent == busy_at && !busy_done) begin
                b_start   = 1'b1;
                busy_done = 1'b1;
            end
            if (colour_at > 0 && sent >= colour_at) begin
                b_fg = ~fg;
                b_bg = ~bg;
            end
            if (b_rdy) begin
                b_rdy = 1'b0;
            end else if (b_req && sent < B_CHARS) begin
                if (!waiting) begin
                    waiting = 1'b1;
                    delay   = $urandom_range(2);
                end
                if (delay == 0) begin
                    ch  = char_fn(sent);
                    col = sent % B_CIW;
                    fr  = (sent / B_CIW) % B_FH;
                    exp_addr = {ch, 3'(fr)};
                    row = font_fn(exp_addr);
                    for (int p = 0; p < FW; p++) begin
                        sq_b.push_back('{data: row[FW-1-p] ? fg : bg,
                                         sof:  (sent == 0 && p == 0),
                                         eol:  (p == FW - 1 && col == B_CIW - 1)});
                    end
                    b_rdy  = 1'b1;
                    b_char = ch;
                    addr_pending = 1'b1;
                    waiting = 1'b0;
                    sent++;
                end else begin
                    delay--;
                end
            end
            step();
        end
        b_start = 1'b0;
        b_ready = 1'b1;
        check("b_done_seen", 32'(got_done), 32'd1);
        check("b_pixel_count", 32'(b_acc), 32'(B_PIX));
        check("b_eol_count", 32'(b_eols), 32'(B_CIH * B_FH));
        check("b_sof_count", 32'(b_sofs), 32'd1);
        check("b_char_count", 32'(sent), 32'(B_CHARS));
        check("b_sb_empty", 32'(sq_b.size()), 32'd0);
        check("b_read_stb_count", 32'(b_rfs_cnt), 32'd1);
        step();
        check("b_done_count", 32'(b_done_cnt), 32'd1);
        check("b_idle_after_done", 32'(b_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_start = 0; s_rdy = 0; s_char = '0; s_rom_pattern = '0;
        s_fg = '0; s_bg = '0; s_ready = 1'b1;
        b_start = 0; b_rdy = 0; b_char = '0; b_fg = '0; b_bg = '0; b_ready = 1'b1;

        vecs[0] = '{ch: 8'h41, rom: 5'b10101, fg: 24'hFFFFFF, bg: 24'h000000, addr: 11'h208,
                    p0: 24'hFFFFFF, p1: 24'h000000, p2: 24'hFFFFFF, p3: 24'h000000, p4: 24'hFFFFFF};
        vecs[1] = '{ch: 8'h00, rom: 5'b11111, fg: 24'h123456, bg: 24'hABCDEF, addr: 11'h000,
                    p0: 24'h123456, p1: 24'h123456, p2: 24'h123456, p3: 24'h123456, p4: 24'h123456};
        vecs[2] = '{ch: 8'hFF, rom: 5'b00000, fg: 24'h777777, bg: 24'h00FF00, addr: 11'h7F8,
                    p0: 24'h00FF00, p1: 24'h00FF00, p2: 24'h00FF00, p3: 24'h00FF00, p4: 24'h00FF00};
        vecs[3] = '{ch: 8'h5A, rom: 5'b10011, fg: 24'hFF0000, bg: 24'h0000FF, addr: 11'h2D0,
                    p0: 24'hFF0000, p1: 24'h0000FF, p2: 24'h0000FF, p3: 24'hFF0000, p4: 24'hFF0000};

        rst = 1'b1;
        step();
        step();
        check_small_idle("s_reset_outputs");
        check_big_idle("b_reset_outputs");
        rst = 1'b0;
        step();
        check_small_idle("s_idle_outputs");
        check_big_idle("b_idle_outputs");

        for (int v = 0; v < 4; v++) run_small(v, 1'b0);
        run_small(0, 1'b1);

        run_big(24'hC0FFEE, 24'h102030, 0, 20, 30);
        run_big(24'h00FF00, 24'hFF00FF, 10, 0, 0);
        run_big(24'h123456, 24'h654321, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
